// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control sequencer: FSM states,
// instruction class codes, the halt encoding and the move-pair table.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  // Instruction class lives in instr[8:7].
  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_MEM = 2'b11;

  localparam logic [8:0] HALT_CODE = 9'b010000000;

  // Width of the memory wait counter; holds MEM_LAT-1 for MEM_LAT up to 15.
  localparam int WAIT_W = 4;

  // Legal move operand pairs {a,b} = instr[3:0]; entry 0 is the rightmost.
  localparam int MV_PAIRS = 6;
  localparam logic [MV_PAIRS-1:0][3:0] MV_PAIR = {
    4'b1110, 4'b1101, 4'b1001, 4'b1100, 4'b1000, 4'b0100
  };

  // Register routing {src,dst} per pair, selected by instr[4].
  localparam logic [MV_PAIRS-1:0][3:0] MV_ROUTE_LO = {
    4'b0111, 4'b0110, 4'b0100, 4'b0011, 4'b0010, 4'b0001
  };
  localparam logic [MV_PAIRS-1:0][3:0] MV_ROUTE_HI = {
    4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1001, 4'b1000
  };

  typedef struct packed {
    logic branch_en;
    logic write_en;
    logic mem_read;
    logic mem_write;
    logic use_immediate;
    logic write_reg_en;
    logic special_en;
  } ctrl_flags_t;

endpackage

// File: rtl/instr_classifier.sv
// Pure combinational decode of one 9-bit instruction word into control
// flags, move routing and the halt/memory indications the FSM needs.
module instr_classifier
  import ctrl_pkg::*;
(
  input  logic [8:0]  instr,
  output ctrl_flags_t flags,
  output logic [1:0]  mv_src,
  output logic [1:0]  mv_dst,
  output logic        is_halt,
  output logic        is_mem
);

  logic       pair_hit;
  logic [3:0] route;
  logic       is_move;

  // Decode class, move table lookup and halt detection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    flags    = '0;
    mv_src   = 2'd0;
    mv_dst   = 2'd0;
    pair_hit = 1'b0;
    route    = 4'd0;
    is_halt  = (instr == HALT_CODE);
    is_mem   = (instr[8:7] == CLS_MEM);

    for (int i = 0; i < MV_PAIRS; i++) begin
      if (instr[3:0] == MV_PAIR[i]) begin
        pair_hit = 1'b1;
        route    = instr[4] ? MV_ROUTE_HI[i] : MV_ROUTE_LO[i];
      end
    end
    is_move = pair_hit && (instr[8:5] == 4'b0000);

    case (instr[8:7])
      CLS_R: begin
        flags.write_en = 1'b1;
        if (is_move) begin
          flags.write_reg_en = 1'b1;
          flags.special_en   = 1'b1;
          mv_src             = route[3:2];
          mv_dst             = route[1:0];
        end
      end
      CLS_BR:  flags.branch_en = !is_halt;
      CLS_IMM: begin
        flags.write_en      = 1'b1;
        flags.use_immediate = 1'b1;
      end
      default: begin
        if (instr[6]) begin
          flags.mem_write = 1'b1;
        end else begin
          flags.mem_read     = 1'b1;
          flags.write_en     = 1'b1;
          flags.write_reg_en = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: accepts one instruction per cycle in RUN, presents
// its registered decode for one cycle, stalls for memory ops, and halts on
// the halt word until restarted.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [8:0]       instr,
  input  logic             start,
  output logic             instr_ready,
  output logic             ctrl_valid,
  output logic             branch_en,
  output logic             write_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic             use_immediate,
  output logic             write_reg_en,
  output logic             special_en,
  output logic [1:0]       mv_src,
  output logic [1:0]       mv_dst,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              done_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              accept;

  ctrl_flags_t dec_flags, flags_q;
  logic [1:0]  dec_mv_src, dec_mv_dst;
  logic        dec_is_halt, dec_is_mem;

  instr_classifier u_classifier (
    .instr   (instr),
    .flags   (dec_flags),
    .mv_src  (dec_mv_src),
    .mv_dst  (dec_mv_dst),
    .is_halt (dec_is_halt),
    .is_mem  (dec_is_mem)
  );

  assign instr_ready = (state == ST_RUN);
  assign accept      = instr_valid && instr_ready;

  // Next-state, wait counter, sticky done and saturating count.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    done_nxt  = done;
    count_nxt = instr_count;

    case (state)
      ST_RUN: begin
        if (accept) begin
          if (dec_is_halt) begin
            state_nxt = ST_HALT;
            done_nxt  = 1'b1;
          end else if (dec_is_mem && (MEM_LAT > 1)) begin
            state_nxt = ST_MEM_WAIT;
            wait_nxt  = WAIT_LOAD;
          end
        end
      end
      ST_MEM_WAIT: begin
        wait_nxt = wait_cnt - WAIT_W'(1);
        if (wait_cnt == WAIT_W'(1)) state_nxt = ST_RUN;
      end
      ST_HALT: begin
        if (start) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (accept && (instr_count != '1)) count_nxt = instr_count + CNT_W'(1);
  end

  // State register and registered control outputs, zeroed when idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      done        <= 1'b0;
      instr_count <= '0;
      ctrl_valid  <= 1'b0;
      flags_q     <= '0;
      mv_src      <= 2'd0;
      mv_dst      <= 2'd0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      done        <= done_nxt;
      instr_count <= count_nxt;
      ctrl_valid  <= accept;
      flags_q     <= accept ? dec_flags  : '0;
      mv_src      <= accept ? dec_mv_src : 2'd0;
      mv_dst      <= accept ? dec_mv_dst : 2'd0;
    end
  end

  assign branch_en     = flags_q.branch_en;
  assign write_en      = flags_q.write_en;
  assign mem_read      = flags_q.mem_read;
  assign mem_write     = flags_q.mem_write;
  assign use_immediate = flags_q.use_immediate;
  assign write_reg_en  = flags_q.write_reg_en;
  assign special_en    = flags_q.special_en;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected decodes are queued on
// acceptance and compared against the registered outputs one cycle later.
module tb_control_sequencer;

  typedef struct packed {
    logic       valid;
    logic       br;
    logic       we;
    logic       mr;
    logic       mw;
    logic       imm;
    logic       wr;
    logic       sp;
    logic [1:0] src;
    logic [1:0] dst;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, start;
  logic [8:0] instr;
  logic       instr_ready, ctrl_valid, branch_en, write_en, mem_read, mem_write;
  logic       use_immediate, write_reg_en, special_en, done;
  logic [1:0] mv_src, mv_dst;
  logic [3:0] instr_count;

  // Second instance with single-cycle memory latency.
  logic        v1, s1;
  logic [8:0]  i1;
  logic        ready1, cv1, br1, we1, mr1, mw1, imm1, wr1, sp1, done1;
  logic [1:0]  src1, dst1;
  logic [15:0] count1;

  int   checks   = 0;
  int   failures = 0;
  int   exp_count = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  control_sequencer #(.MEM_LAT(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .start(start),
    .instr_ready(instr_ready), .ctrl_valid(ctrl_valid), .branch_en(branch_en),
    .write_en(write_en), .mem_read(mem_read), .mem_write(mem_write),
    .use_immediate(use_immediate), .write_reg_en(write_reg_en), .special_en(special_en),
    .mv_src(mv_src), .mv_dst(mv_dst), .done(done), .instr_count(instr_count)
  );

  control_sequencer #(.MEM_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr(i1), .start(s1),
    .instr_ready(ready1), .ctrl_valid(cv1), .branch_en(br1),
    .write_en(we1), .mem_read(mr1), .mem_write(mw1),
    .use_immediate(imm1), .write_reg_en(wr1), .special_en(sp1),
    .mv_src(src1), .mv_dst(dst1), .done(done1), .instr_count(count1)
  );

  // Reference decode written as explicit tables.
  function automatic exp_t ref_decode(input logic [8:0] w);
    exp_t e = '0;
    e.valid = 1'b1;
    if (w == 9'b010000000) return e;
    case (w[8:7])
      2'b00: begin
        e.we = 1'b1;
        if (w[8:5] == 4'b0000) begin
          case ({w[4], w[3:0]})
            5'b0_0100: {e.src, e.dst} = {2'd0, 2'd1};
            5'b0_1000: {e.src, e.dst} = {2'd0, 2'd2};
            5'b0_1100: {e.src, e.dst} = {2'd0, 2'd3};
            5'b0_1001: {e.src, e.dst} = {2'd1, 2'd0};
            5'b0_1101: {e.src, e.dst} = {2'd1, 2'd2};
            5'b0_1110: {e.src, e.dst} = {2'd1, 2'd3};
            5'b1_0100: {e.src, e.dst} = {2'd2, 2'd0};
            5'b1_1000: {e.src, e.dst} = {2'd2, 2'd1};
            5'b1_1100: {e.src, e.dst} = {2'd2, 2'd3};
            5'b1_1001: {e.src, e.dst} = {2'd3, 2'd0};
            5'b1_1101: {e.src, e.dst} = {2'd3, 2'd1};
            5'b1_1110: {e.src, e.dst} = {2'd3, 2'd2};
            default:   e.we = 1'b1;
          endcase
          case (w[3:0])
            4'b0100, 4'b1000, 4'b1100, 4'b1001, 4'b1101, 4'b1110: begin
              e.wr = 1'b1;
              e.sp = 1'b1;
            end
            default: ;
          endcase
        end
      end
      2'b01: e.br = 1'b1;
      2'b10: begin e.we = 1'b1; e.imm = 1'b1; end
      default: begin
        if (w[6]) e.mw = 1'b1;
        else begin e.mr = 1'b1; e.we = 1'b1; e.wr = 1'b1; end
      end
    endcase
    return e;
  endfunction

  // One clock: queue the expectation for any acceptance, then compare outputs.
  task automatic step();
    logic acc;
    exp_t e, obs;
    acc = instr_valid && instr_ready && rst_n;
    if (acc) begin
      sb.push_back(ref_decode(instr));
      if (exp_count != 15) exp_count++;
    end
    @(posedge clk);
    #1;
    if (!rst_n) sb.delete();
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {ctrl_valid, branch_en, write_en, mem_read, mem_write, use_immediate,
           write_reg_en, special_en, mv_src, mv_dst};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL ctrl_out instr=%b got=%b expected=%b", instr, obs, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; start = 1'b0;
    v1 = 1'b0; i1 = '0; s1 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_count = 0;
    checks++;
    if ({ctrl_valid, branch_en, write_en, mem_read, mem_write, use_immediate,
         write_reg_en, special_en, mv_src, mv_dst, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got_valid=%b got_done=%b expected all 0", ctrl_valid, done);
    end
    checks++;
    if (instr_ready !== 1'b1 || instr_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_ready_count got=%b/%0d expected=1/0", instr_ready, instr_count);
    end
  endtask

  task automatic test_move();
    instr_valid = 1'b1; instr = 9'b000011101;
    step();
    instr_valid = 1'b0;
    checks++;
    if (mv_src !== 2'd3 || mv_dst !== 2'd1 || special_en !== 1'b1) begin
      failures++;
      $display("FAIL move_route got src=%0d dst=%0d sp=%b expected 3 1 1", mv_src, mv_dst, special_en);
    end
    step();
  endtask

  task automatic test_patterns();
    logic [8:0] words [6];
    words = '{9'b000100000, 9'b101010101, 9'b011111111, 9'b000000001,
              9'b000000100, 9'b000011010};
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1; instr = words[i];
      step();
    end
    instr_valid = 1'b0;
    step();
  endtask

  task automatic test_mem();
    logic [8:0] words [2];
    words = '{9'b110000000, 9'b111000000};
    for (int k = 0; k < 2; k++) begin
      instr_valid = 1'b1; instr = words[k];
      step();
      start = 1'b1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (instr_ready !== (c == 2)) begin
          failures++;
          $display("FAIL mem_wait_ready cycle=%0d got=%b expected=%b", c, instr_ready, (c == 2));
        end
        if (c < 2) step();
      end
      start = 1'b0;
      instr_valid = 1'b0;
    end
    step();
  endtask

  task automatic test_mem_lat1();
    v1 = 1'b1; i1 = 9'b110000000;
    step();
    v1 = 1'b0;
    checks++;
    if (ready1 !== 1'b1 || mr1 !== 1'b1 || cv1 !== 1'b1) begin
      failures++;
      $display("FAIL mem_lat1 got ready=%b mem_read=%b valid=%b expected 1 1 1", ready1, mr1, cv1);
    end
  endtask

  task automatic test_halt();
    int held;
    instr_valid = 1'b1; instr = 9'b010000000;
    step();
    checks++;
    if (done !== 1'b1 || branch_en !== 1'b0 || instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL halt_enter got done=%b br=%b ready=%b expected 1 0 0", done, branch_en, instr_ready);
    end
    held = exp_count;
    instr = 9'b000000000;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (instr_count !== 4'(held) || done !== 1'b1) begin
      failures++;
      $display("FAIL halt_hold got count=%0d done=%b expected %0d 1", instr_count, done, held);
    end
    instr_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL halt_restart got ready=%b done=%b expected 1 0", instr_ready, done);
    end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = 0;
    instr_valid = 1'b1; instr = 9'b011000001;
    for (int n = 0; n < 17; n++) step();
    instr_valid = 1'b0;
    checks++;
    if (instr_count !== 4'(exp_count) || exp_count != 15) begin
      failures++;
      $display("FAIL count_saturate got=%0d expected=15", instr_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    instr_valid = 1'b1; instr = 9'b110000000;
    step();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = 0;
    checks++;
    if (instr_ready !== 1'b1 || ctrl_valid !== 1'b0 || instr_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_mem got ready=%b valid=%b count=%0d expected 1 0 0",
               instr_ready, ctrl_valid, instr_count);
    end
    step();
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_mem_after got ready=%b expected 1", instr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_patterns();
    test_mem();
    test_mem_lat1();
    test_halt();
    test_back_to_back();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles a load/store occupies the memory port, legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16: width of the accepted-instruction counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port instr_valid  in  1  an instruction is offered.
REQ-006 SHALL have port instr  in  9  offered instruction word.
REQ-007 SHALL have port start  in  1  restart request, honoured only in HALT.
REQ-008 SHALL have port instr_ready  out  1  instruction accepted when instr_valid and instr_ready are both 1.
REQ-009 SHALL have port ctrl_valid  out  1  control outputs describe one accepted instruction.
REQ-010 SHALL have ports branch_en, write_en, mem_read, mem_write, use_immediate, write_reg_en, special_en  out  1 each  registered control flags.
REQ-011 SHALL have ports mv_src, mv_dst  out  2 each  move source and destination register.
REQ-012 SHALL have port done  out  1  sticky halt indication.
REQ-013 SHALL have port instr_count  out  CNT_W  saturating count of accepted instructions.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT and HALT.
REQ-015 SHALL drive instr_ready=1 only in RUN.
REQ-016 SHALL register the decode of each accepted instruction, presenting it with ctrl_valid=1 for exactly one cycle, in the cycle after acceptance (latency 1).
REQ-017 SHALL drive ctrl_valid and every control flag, mv_src and mv_dst to 0 in any cycle with no accepted instruction; stale values are forbidden.
REQ-018 SHALL use class = instr[8:7]; 00 R-type: write_en=1.
REQ-019 SHALL decode class 01 as branch: branch_en=1.
REQ-020 SHALL decode class 10 as immediate: write_en=1, use_immediate=1.
REQ-021 SHALL decode class 11 as memory: instr[6]=1 gives mem_write=1; instr[6]=0 gives mem_read=1, write_en=1, write_reg_en=1.
REQ-022 SHALL treat instr==9'b010000000 as halt: all control flags 0, done=1 from the next cycle, FSM enters HALT.
REQ-023 SHALL decode a move when instr[8:5]=0000 and (a=instr[3:2], b=instr[1:0]) is one of (1,0),(2,0),(3,0),(2,1),(3,1),(3,2): write_en=write_reg_en=special_en=1, with mv_src and mv_dst per REQ-024 and REQ-025; all other class-00 words are plain R-type.
REQ-024 SHALL map a move with instr[4]=0 in that pair order to (src,dst): (0,1),(0,2),(0,3),(1,0),(1,2),(1,3).
REQ-025 SHALL map a move with instr[4]=1 in that pair order to (src,dst): (2,0),(2,1),(2,3),(3,0),(3,1),(3,2).
REQ-026 SHALL move from RUN to MEM_WAIT on acceptance of a class-11 word when MEM_LAT>1, loading the wait counter with MEM_LAT-1.
REQ-027 SHALL decrement the wait counter each cycle in MEM_WAIT and return to RUN when it reaches 0 (instr_ready low for MEM_LAT-1 cycles); with MEM_LAT=1, the FSM stays in RUN.
REQ-028 SHALL hold HALT and ignore instr_valid; start=1 in HALT gives RUN and done=0 next cycle; start is ignored in RUN and MEM_WAIT.
REQ-029 SHALL increment instr_count on every acceptance (halt included) and saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, force state RUN, wait counter 0, instr_count 0, done 0, and all registered outputs 0; instr_ready is 1 after release.
REQ-031 SHALL let reset take priority over start, instr_valid and any MEM_WAIT or HALT in progress, with no pending outputs emitted after release.

Structure
REQ-032 SHALL place the state enum, class codes (R/BR/IMM/MEM), HALT_CODE and the move-pair table in shared package ctrl_pkg.
REQ-033 SHALL contain one combinational sub-module, instr_classifier (instr in; flags, mv_src, mv_dst, is_halt, is_mem out), with all state in control_sequencer.

Verification
REQ-034 SHALL check: rst_n=0 for 2 cycles, then 1 -> all outputs 0, instr_ready=1, instr_count=0.
REQ-035 SHALL check: accept 9'b000011101 -> next cycle ctrl_valid=1, write_en=write_reg_en=special_en=1, mv_src=3, mv_dst=1; following cycle all 0.
REQ-036 SHALL check, with MEM_LAT=3: accept 9'b110000000 -> mem_read=write_en=write_reg_en=1 for 1 cycle, instr_ready=0 for 2 cycles, then 1; 9'b111000000 -> mem_write=1 only.
REQ-037 SHALL check: accept 9'b010000000 -> done=1, branch_en=0; instr_valid held 5 cycles -> no acceptance, count unchanged; start=1 -> instr_ready=1 and done=0 next cycle.
REQ-038 SHALL check, with CNT_W=4: 17 back-to-back acceptances -> instr_count=15.
REQ-039 SHALL check: rst_n=0 on the first MEM_WAIT cycle -> after release state RUN, instr_ready=1, ctrl_valid=0.
